// File: rtl/weight_feeder_if.sv
// Weight-load bus: start request, weight RAM read port, core weight outputs and status.
// master = weight_feeder, slave = controller / RAM / computing-core side.
interface weight_feeder_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                    start;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    mem_ren;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic [4*WIDTH-1:0]      mem_rdata;
  logic                    weight_load;
  logic [WIDTH-1:0]        weight0;
  logic [WIDTH-1:0]        weight1;
  logic [WIDTH-1:0]        weight2;
  logic [WIDTH-1:0]        weight3;
  logic [3:0]              load_index;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, base_addr, mem_rdata,
    output mem_ren, mem_raddr, weight_load,
           weight0, weight1, weight2, weight3,
           load_index, busy, done
  );

  modport slave (
    output start, base_addr, mem_rdata,
    input  mem_ren, mem_raddr, weight_load,
           weight0, weight1, weight2, weight3,
           load_index, busy, done
  );
endinterface

// File: rtl/weight_feeder.sv
// Reads one 3x3 kernel set (9 words, 4 filters per word) from weight RAM and
// presents it to the computing core as a contiguous 9-cycle weight_load burst.
module weight_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst,
  weight_feeder_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_K = 4'd8;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    ren_q, ren_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [3:0]              idx_q, idx_d;
  logic [4*WIDTH-1:0]      w_q, w_d;
  logic [4*WIDTH-1:0]      w_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      raddr_q  <= '0;
      ren_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      idx_q    <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      raddr_q  <= raddr_d;
      ren_q    <= ren_d;
      rd_vld_q <= rd_vld_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
    end
  end

  // Read-issue FSM: the address and enable for the next cycle are decided here
  // so that mem_ren/mem_raddr leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    ren_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          raddr_d = bus.base_addr;
          ren_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cnt_q == LAST_K) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          raddr_d = raddr_q + ADDR_WIDTH'(1);
          ren_d   = 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index advances only while the next cycle is also a load cycle, so it
  // falls back to 0 right after the 9th word without a separate clear.
  always_comb begin
    rd_vld_d = ren_q;
    idx_d    = (rd_vld_q && ren_q) ? idx_q + 4'd1 : '0;
    w_d      = rd_vld_q ? bus.mem_rdata : w_q;
  end

  // RAM data is forwarded during the load cycle itself to meet the 1-cycle
  // read latency; w_q keeps the last word on the outputs between loads.
  assign w_out = rd_vld_q ? bus.mem_rdata : w_q;

  assign bus.mem_ren     = ren_q;
  assign bus.mem_raddr   = raddr_q;
  assign bus.weight_load = rd_vld_q;
  assign bus.weight0     = w_out[WIDTH-1:0];
  assign bus.weight1     = w_out[2*WIDTH-1:WIDTH];
  assign bus.weight2     = w_out[3*WIDTH-1:2*WIDTH];
  assign bus.weight3     = w_out[4*WIDTH-1:3*WIDTH];
  assign bus.load_index  = idx_q;
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);

endmodule
